// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the 10-bit processor instruction sequencer.
// Contents: instruction field positions, opcode constants, FSM state
// encodings and small opcode-class helpers used by the sequencer and
// its next-pc mux.
package instr_sequencer_pkg;

    localparam int INSTR_W = 10;
    localparam int OPC_MSB = 9;
    localparam int OPC_LSB = 6;
    localparam int OPND_W  = 6;

    localparam logic [3:0] OPC_ALU0         = 4'd0;
    localparam logic [3:0] OPC_SET_IMM      = 4'd1;
    localparam logic [3:0] OPC_LOAD_QUERY   = 4'd2;
    localparam logic [3:0] OPC_ALU3         = 4'd3;
    localparam logic [3:0] OPC_JUMP_BACK    = 4'd4;
    localparam logic [3:0] OPC_ALU5         = 4'd5;
    localparam logic [3:0] OPC_IF_DONE      = 4'd6;
    localparam logic [3:0] OPC_STORE_ZERO   = 4'd7;
    localparam logic [3:0] OPC_ALU8         = 4'd8;
    localparam logic [3:0] OPC_JUMP_FP      = 4'd9;
    localparam logic [3:0] OPC_SKIP_NOT_ONE = 4'd10;
    localparam logic [3:0] OPC_PUSH         = 4'd11;
    localparam logic [3:0] OPC_POP          = 4'd12;
    localparam logic [3:0] OPC_ALU13        = 4'd13;
    localparam logic [3:0] OPC_RETURN       = 4'd14;
    localparam logic [3:0] OPC_ILLEGAL      = 4'd15;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } seqState_t;

    // Opcodes that write the register file during EXEC.
    function automatic logic isRegWriteOp(input logic [3:0] opc);
        return (opc == OPC_ALU0) || (opc == OPC_SET_IMM) || (opc == OPC_ALU3) ||
               (opc == OPC_ALU5) || (opc == OPC_ALU8)    || (opc == OPC_ALU13);
    endfunction

    // Opcodes that need a data-memory access after EXEC.
    function automatic logic isMemOp(input logic [3:0] opc);
        return (opc == OPC_PUSH) || (opc == OPC_POP) ||
               (opc == OPC_LOAD_QUERY) || (opc == OPC_STORE_ZERO);
    endfunction

endpackage

// File: rtl/instr_next_pc.sv
// Combinational next-pc mux for the instruction sequencer.
// Ports:
//   opcode  in   4     decoded opcode
//   pc      in   PC_W  current program counter
//   operand in   6     instruction operand field (unsigned offset)
//   link    in   PC_W  saved return address
//   flagOne in   1     datapath "value == 1" flag
//   nextPc  out  PC_W  pc value taken when the instruction retires
// All arithmetic wraps modulo 2**PC_W.
module instr_next_pc
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [PC_W-1:0]   pc,
    input  logic [OPND_W-1:0] operand,
    input  logic [PC_W-1:0]   link,
    input  logic              flagOne,
    output logic [PC_W-1:0]   nextPc
);

    logic [PC_W-1:0] opndExt;
    logic [PC_W-1:0] pcPlusOne;

    assign opndExt   = PC_W'(operand);
    assign pcPlusOne = pc + PC_W'(1);

    always_comb begin
        nextPc = pcPlusOne;
        case (opcode)
            OPC_JUMP_BACK:    nextPc = pc - opndExt;
            OPC_JUMP_FP:      nextPc = pc + opndExt;
            OPC_SKIP_NOT_ONE: nextPc = flagOne ? pcPlusOne : pc + PC_W'(2);
            OPC_RETURN:       nextPc = link;
            default:          ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 10-bit processor.
// Owns pc, sp, link and ir; one instruction in flight.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/addr/ack/rdata   instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/ack      data access handshake (push/pop/load/store)
//   alu_op, operand           ir opcode and ir[5:0] for the datapath
//   reg_we                    one-cycle register-file write strobe
//   flag_one, done_in         datapath condition flags
//   halted, illegal           stop status; illegal is sticky until rst
//
// state     | meaning
// ST_FETCH  | imem_req high at pc, wait for imem_ack, latch ir
// ST_DECODE | one idle cycle; opcode 15 goes to HALT
// ST_EXEC   | reg_we for ALU ops, pc update or hand-off to MEM
// ST_MEM    | dmem_req held until dmem_ack, then pc+1
// ST_HALT   | absorbing, all strobes low, acks ignored
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int              PC_W    = 8,
    parameter int              DA_W    = 8,
    parameter logic [DA_W-1:0] SP_INIT = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DA_W-1:0]    dmem_addr,
    input  logic               dmem_ack,
    output logic [3:0]         alu_op,
    output logic [OPND_W-1:0]  operand,
    output logic               reg_we,
    input  logic               flag_one,
    input  logic               done_in,
    output logic               halted,
    output logic               illegal
);

    seqState_t          state, nextState;
    logic [PC_W-1:0]    pc, link, nextPc;
    logic [DA_W-1:0]    sp;
    logic [INSTR_W-1:0] ir;
    logic               illegalQ;
    logic [3:0]         opcode;

    assign opcode    = ir[OPC_MSB:OPC_LSB];
    assign alu_op    = opcode;
    assign operand   = ir[OPND_W-1:0];
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);
    assign illegal   = illegalQ;

    instr_next_pc #(.PC_W(PC_W)) uNextPc (
        .opcode  (opcode),
        .pc      (pc),
        .operand (operand),
        .link    (link),
        .flagOne (flag_one),
        .nextPc  (nextPc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc       <= '0;
            sp       <= SP_INIT;
            link     <= '0;
            ir       <= '0;
            illegalQ <= 1'b0;
        end else begin
            state <= nextState;
            if (state == ST_FETCH && imem_ack)
                ir <= imem_rdata;
            if (state == ST_DECODE && opcode == OPC_ILLEGAL)
                illegalQ <= 1'b1;
            // A taken ifDone goes to HALT with pc left where it was.
            if (state == ST_EXEC && nextState == ST_FETCH) begin
                pc <= nextPc;
                if (opcode == OPC_JUMP_FP)
                    link <= pc + PC_W'(1);
            end
            if (state == ST_MEM && dmem_ack) begin
                pc <= pc + PC_W'(1);
                if (opcode == OPC_PUSH)
                    sp <= sp - DA_W'(1);
                else if (opcode == OPC_POP)
                    sp <= sp + DA_W'(1);
            end
        end
    end

    always_comb begin
        nextState = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_addr = '0;
        reg_we    = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    nextState = ST_DECODE;
            end
            ST_DECODE: begin
                nextState = (opcode == OPC_ILLEGAL) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                reg_we = isRegWriteOp(opcode);
                if (isMemOp(opcode))
                    nextState = ST_MEM;
                else if (opcode == OPC_IF_DONE && done_in)
                    nextState = ST_HALT;
                else
                    nextState = ST_FETCH;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                case (opcode)
                    OPC_PUSH: begin
                        dmem_addr = sp;
                        dmem_we   = 1'b1;
                    end
                    OPC_POP:        dmem_addr = sp + DA_W'(1);
                    OPC_LOAD_QUERY: dmem_addr = DA_W'(operand);
                    OPC_STORE_ZERO: dmem_we   = 1'b1;
                    default:        ;
                endcase
                if (dmem_ack) begin
                    nextState = ST_FETCH;
                    reg_we    = (opcode == OPC_POP) || (opcode == OPC_LOAD_QUERY);
                end
            end
            ST_HALT: ;
            default: nextState = ST_FETCH;
        endcase
        // Keep every request and strobe quiet for as long as reset is held,
        // so an access in progress is abandoned immediately.
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            reg_we   = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: fetch timing, jumps/link/return,
// skip, stack push/pop, load/store, wrap, ifDone/illegal halt and reset abort.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [9:0] imem_rdata = '0;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic       dmem_ack = 1'b0;
    logic [3:0] alu_op;
    logic [5:0] operand;
    logic       reg_we;
    logic       flag_one = 1'b0;
    logic       done_in = 1'b0;
    logic       halted;
    logic       illegal;

    int nTests = 0;
    int nFail  = 0;

    instr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_ack   (dmem_ack),
        .alu_op     (alu_op),
        .operand    (operand),
        .reg_we     (reg_we),
        .flag_one   (flag_one),
        .done_in    (done_in),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in FETCH; ends in DECODE.
    task automatic fetch(input logic [9:0] instr, input logic [7:0] expAddr, input string tag);
        chk({tag, "_ireq"}, imem_req, 1);
        chk({tag, "_iaddr"}, imem_addr, expAddr);
        imem_rdata = instr;
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk({tag, "_opnd"}, operand, instr[5:0]);
        chk({tag, "_dec_ireq"}, imem_req, 0);
    endtask

    // Starts in FETCH; ends one cycle after EXEC (FETCH, MEM or HALT).
    task automatic doInstr(input logic [9:0] instr, input logic [7:0] expAddr,
                           input logic expRegWe, input string tag);
        fetch(instr, expAddr, tag);
        step();
        chk({tag, "_aluop"}, alu_op, instr[9:6]);
        chk({tag, "_regwe"}, reg_we, expRegWe);
        step();
        chk({tag, "_regwe_off"}, reg_we, 0);
    endtask

    // Starts in MEM; acks after 'delay' extra cycles; ends back in FETCH.
    task automatic memPhase(input logic [7:0] expAddr, input logic expWe, input int delay,
                            input logic expRegWe, input string tag);
        chk({tag, "_dreq"}, dmem_req, 1);
        chk({tag, "_ireq_lo"}, imem_req, 0);
        chk({tag, "_daddr"}, dmem_addr, expAddr);
        chk({tag, "_dwe"}, dmem_we, expWe);
        for (int i = 0; i < delay; i++) begin
            step();
            chk({tag, "_dreq_hold"}, dmem_req, 1);
            chk({tag, "_daddr_hold"}, dmem_addr, expAddr);
            chk({tag, "_dwe_hold"}, dmem_we, expWe);
        end
        dmem_ack = 1'b1;
        #1;
        chk({tag, "_ack_regwe"}, reg_we, expRegWe);
        step();
        dmem_ack = 1'b0;
        #1;
        chk({tag, "_dreq_drop"}, dmem_req, 0);
        chk({tag, "_ireq_back"}, imem_req, 1);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ireq", imem_req, 0);
        chk("rst_dreq", dmem_req, 0);
        chk("rst_regwe", reg_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_iaddr", imem_addr, 8'h00);
        chk("rst_aluop", alu_op, 0);
        chk("rst_opnd", operand, 0);
        rst = 1'b0;
        #1;

        // setImmediate x3 with ack in the first request cycle
        for (int i = 0; i < 3; i++) doInstr(10'h045, 8'(i), 1'b1, "setImm");
        chk("setImm_pc3", imem_addr, 8'h03);

        // jumpOrInitFp to 0x10, then 0x10 -> 0x14 with link 0x11, then return
        doInstr(10'h24D, 8'h03, 1'b0, "jfp0");
        doInstr(10'h244, 8'h10, 1'b0, "jfp");
        chk("jfp_target", imem_addr, 8'h14);
        doInstr(10'h380, 8'h14, 1'b0, "ret");
        chk("ret_target", imem_addr, 8'h11);

        // jumpBackOrInit to 5, skipIfNotOne both ways
        doInstr(10'h10C, 8'h11, 1'b0, "jback");
        flag_one = 1'b0;
        doInstr(10'h280, 8'h05, 1'b0, "skip0");
        chk("skip0_target", imem_addr, 8'h07);
        doInstr(10'h102, 8'h07, 1'b0, "jback2");
        flag_one = 1'b1;
        doInstr(10'h280, 8'h05, 1'b0, "skip1");
        chk("skip1_target", imem_addr, 8'h06);
        flag_one = 1'b0;

        // push x2, pop x2, loadQuery, storeToZero, push to confirm sp
        doInstr(10'h2C0, 8'h06, 1'b0, "push0");
        memPhase(8'hFF, 1'b1, 2, 1'b0, "push0");
        doInstr(10'h2C0, 8'h07, 1'b0, "push1");
        memPhase(8'hFE, 1'b1, 0, 1'b0, "push1");
        doInstr(10'h300, 8'h08, 1'b0, "pop0");
        memPhase(8'hFE, 1'b0, 1, 1'b1, "pop0");
        doInstr(10'h300, 8'h09, 1'b0, "pop1");
        memPhase(8'hFF, 1'b0, 0, 1'b1, "pop1");
        doInstr(10'h0AA, 8'h0A, 1'b0, "ldq");
        memPhase(8'h2A, 1'b0, 0, 1'b1, "ldq");
        doInstr(10'h1C0, 8'h0B, 1'b0, "st0");
        memPhase(8'h00, 1'b1, 0, 1'b0, "st0");
        doInstr(10'h2C0, 8'h0C, 1'b0, "push2");
        memPhase(8'hFF, 1'b1, 0, 1'b0, "push2");

        // pc wrap: 0x0D - 0x0E = 0xFF, then 0xFF + 1 = 0x00
        doInstr(10'h10E, 8'h0D, 1'b0, "jbwrap");
        doInstr(10'h340, 8'hFF, 1'b1, "op13wrap");
        chk("pc_wrap", imem_addr, 8'h00);

        // ifDone not taken, then taken
        done_in = 1'b0;
        doInstr(10'h180, 8'h00, 1'b0, "ifdone0");
        chk("ifdone0_target", imem_addr, 8'h01);
        done_in = 1'b1;
        doInstr(10'h180, 8'h01, 1'b0, "ifdone1");
        chk("ifdone_halted", halted, 1);
        chk("ifdone_ireq", imem_req, 0);
        chk("ifdone_illegal", illegal, 0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_hold", halted, 1);
            chk("halt_ireq", imem_req, 0);
            chk("halt_dreq", dmem_req, 0);
            chk("halt_regwe", reg_we, 0);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        done_in  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("unhalt_halted", halted, 0);
        chk("unhalt_iaddr", imem_addr, 8'h00);

        // illegal opcode
        fetch(10'h3C0, 8'h00, "ill");
        chk("ill_dec_halted", halted, 0);
        step();
        chk("ill_illegal", illegal, 1);
        chk("ill_halted", halted, 1);
        chk("ill_ireq", imem_req, 0);
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        chk("ill_sticky", illegal, 1);
        chk("ill_halt_hold", halted, 1);
        chk("ill_ireq_hold", imem_req, 0);

        // reset during a data access, then a stale ack
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst2_illegal", illegal, 0);
        chk("rst2_halted", halted, 0);
        doInstr(10'h2C0, 8'h00, 1'b0, "rpush");
        chk("rpush_dreq", dmem_req, 1);
        chk("rpush_daddr", dmem_addr, 8'hFF);
        rst = 1'b1;
        step();
        chk("abort_dreq", dmem_req, 0);
        chk("abort_ireq", imem_req, 0);
        rst = 1'b0;
        #1;
        chk("abort_iaddr", imem_addr, 8'h00);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("stale_dreq", dmem_req, 0);
        chk("stale_iaddr", imem_addr, 8'h00);
        doInstr(10'h2C0, 8'h00, 1'b0, "push3");
        memPhase(8'hFF, 1'b1, 0, 1'b0, "push3");
        chk("push3_next", imem_addr, 8'h01);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
